skein_result_checker: RTL and testbench

Downstream stage of the `skein512` hash core in the mining datapath. Carries each issued nonce through a delay line matched to the core's pipeline latency, so every `hash` output is paired with the nonce that produced it. Compares the hash's most-significant 64 bits against a target and queues winning ("golden") nonces in a small FIFO with a valid/ready output. Also counts hashes checked and hits dropped.

---
 rtl/skein_pkg.sv | 14 +
 rtl/skein_tag_delay.sv | 42 ++++
 rtl/skein_result_checker.sv | 127 ++++++++++++
 tb/tb_skein_result_checker.sv | 269 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/skein_pkg.sv
// Shared widths and tag bundle for the skein512 result-check path.
// Imported by skein_tag_delay and skein_result_checker.
package skein_pkg;
    localparam int NONCE_W    = 32;
    localparam int HASH_W     = 512;
    localparam int TARGET_W   = 64;
    localparam int HASH_CNT_W = 48;
    localparam int DROP_CNT_W = 16;

    typedef struct packed {
        logic               vld;
        logic [NONCE_W-1:0] nonce;
    } tag_t;
endpackage

// File: rtl/skein_tag_delay.sv
// LATENCY-deep {valid, nonce} shift line matching the skein512 core.
// Ports: clk, rst_n, i_clear, i_tag in, o_tag tail tap.
module skein_tag_delay
    import skein_pkg::*;
#(
    parameter int LATENCY = 72
) (
    input  logic clk,
    input  logic rst_n,
    input  logic i_clear,
    input  tag_t i_tag,
    output tag_t o_tag
);

    logic [LATENCY-1:0] r_vld;
    logic [NONCE_W-1:0] r_nonce [LATENCY];

    // Only the valid bits are flushed; stale nonces are harmless.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_vld <= '0;
        end else if (i_clear) begin
            r_vld <= '0;
        end else begin
            r_vld[0] <= i_tag.vld;
            for (int i = 1; i < LATENCY; i++) begin
                r_vld[i] <= r_vld[i-1];
            end
        end
    end

    always_ff @(posedge clk) begin
        r_nonce[0] <= i_tag.nonce;
        for (int i = 1; i < LATENCY; i++) begin
            r_nonce[i] <= r_nonce[i-1];
        end
    end

    assign o_tag.vld   = r_vld[LATENCY-1];
    assign o_tag.nonce = r_nonce[LATENCY-1];

endmodule

// File: rtl/skein_result_checker.sv
// Pairs skein512 hashes with their nonces, flags hits below target and
// queues golden nonces. Ports: issue_*, hash, target in; out_* handshake;
// hash_count / drop_count statistics; clear flushes in-flight work.
module skein_result_checker
    import skein_pkg::*;
#(
    parameter int LATENCY    = 72,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  clear,
    input  logic                  issue_valid,
    input  logic [NONCE_W-1:0]    issue_nonce,
    input  logic [HASH_W-1:0]     hash,
    input  logic [TARGET_W-1:0]   target,
    output logic                  out_valid,
    output logic [NONCE_W-1:0]    out_nonce,
    input  logic                  out_ready,
    output logic [HASH_CNT_W-1:0] hash_count,
    output logic [DROP_CNT_W-1:0] drop_count
);

    localparam int PTR_W = $clog2(FIFO_DEPTH);

    tag_t                  w_issue;
    tag_t                  w_tag;
    logic [TARGET_W-1:0]   w_hash_top;
    logic                  w_unused;

    logic                  r_hit;
    logic [NONCE_W-1:0]    r_hit_nonce;
    logic [HASH_CNT_W-1:0] r_hcnt;
    logic [DROP_CNT_W-1:0] r_drop;

    logic [PTR_W:0]        r_wr_ptr;
    logic [PTR_W:0]        r_rd_ptr;
    logic [NONCE_W-1:0]    r_mem [FIFO_DEPTH];

    logic                  w_empty;
    logic                  w_full;
    logic                  w_pop;
    logic                  w_push;
    logic                  w_drop;

    assign w_issue.vld   = issue_valid;
    assign w_issue.nonce = issue_nonce;

    skein_tag_delay #(
        .LATENCY(LATENCY)
    ) u_tag_delay (
        .clk    (clk),
        .rst_n  (rst_n),
        .i_clear(clear),
        .i_tag  (w_issue),
        .o_tag  (w_tag)
    );

    assign w_hash_top = hash[HASH_W-1 -: TARGET_W];
    assign w_unused   = ^hash[HASH_W-TARGET_W-1:0];

    // Compare stage; strict less-than makes target==0 unreachable.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_hit  <= 1'b0;
            r_hcnt <= '0;
        end else if (clear) begin
            r_hit  <= 1'b0;
            r_hcnt <= '0;
        end else begin
            r_hit  <= w_tag.vld && (w_hash_top < target);
            r_hcnt <= r_hcnt + HASH_CNT_W'(w_tag.vld);
        end
    end

    always_ff @(posedge clk) begin
        r_hit_nonce <= w_tag.nonce;
    end

    // Extra pointer bit separates full from empty when indices match.
    assign w_empty = (r_wr_ptr == r_rd_ptr);
    assign w_full  = (r_wr_ptr[PTR_W] != r_rd_ptr[PTR_W]) &&
                     (r_wr_ptr[PTR_W-1:0] == r_rd_ptr[PTR_W-1:0]);
    assign w_pop   = !w_empty && out_ready;
    // When full, a same-cycle pop frees the slot being overwritten.
    assign w_push  = r_hit && (!w_full || w_pop);
    assign w_drop  = r_hit && w_full && !w_pop;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
        end else if (clear) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
        end else begin
            if (w_push) r_wr_ptr <= r_wr_ptr + (PTR_W+1)'(1);
            if (w_pop)  r_rd_ptr <= r_rd_ptr + (PTR_W+1)'(1);
        end
    end

    // Storage reset keeps out_nonce at zero out of reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                r_mem[i] <= '0;
            end
        end else if (w_push && !clear) begin
            r_mem[r_wr_ptr[PTR_W-1:0]] <= r_hit_nonce;
        end
    end

    // Survives clear so lost hits stay visible across work changes.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_drop <= '0;
        end else if (!clear && w_drop && (r_drop != '1)) begin
            r_drop <= r_drop + DROP_CNT_W'(1);
        end
    end

    assign out_valid  = !w_empty;
    assign out_nonce  = r_mem[r_rd_ptr[PTR_W-1:0]];
    assign hash_count = r_hcnt;
    assign drop_count = r_drop;

endmodule

// File: tb/tb_skein_result_checker.sv
// Self-checking bench for skein_result_checker with a queue-based model.
// Directed test-plan steps followed by randomized traffic.
module tb_skein_result_checker;

    localparam int LAT   = 4;
    localparam int DEPTH = 4;

    logic         clk;
    logic         rst_n;
    logic         clear;
    logic         issue_valid;
    logic [31:0]  issue_nonce;
    logic [511:0] hash;
    logic [63:0]  target;
    logic         out_valid;
    logic [31:0]  out_nonce;
    logic         out_ready;
    logic [47:0]  hash_count;
    logic [15:0]  drop_count;

    skein_result_checker #(
        .LATENCY   (LAT),
        .FIFO_DEPTH(DEPTH)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .clear      (clear),
        .issue_valid(issue_valid),
        .issue_nonce(issue_nonce),
        .hash       (hash),
        .target     (target),
        .out_valid  (out_valid),
        .out_nonce  (out_nonce),
        .out_ready  (out_ready),
        .hash_count (hash_count),
        .drop_count (drop_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] n;
        int          c;
    } fl_t;

    int          nchk = 0;
    int          nerr = 0;
    int          cyc_n = 0;
    logic [63:0] want_top;
    logic [63:0] core_q [$];
    fl_t         m_infl [$];
    logic [31:0] m_fifo [$];
    logic        m_pv;
    logic [31:0] m_pn;
    logic [47:0] m_hc;
    logic [15:0] m_drop;

    task automatic chk(string tag, logic [63:0] obs, logic [63:0] exp);
        nchk++;
        assert (obs === exp) else begin
            nerr++;
            $error("FAIL %s: got %0h want %0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_infl.delete();
        m_fifo.delete();
        m_pv   = 1'b0;
        m_pn   = '0;
        m_hc   = '0;
        m_drop = '0;
    endtask

    // One clock edge of the specified behaviour, using current inputs.
    task automatic model_edge(logic [63:0] ht);
        fl_t t;
        bit  pop;
        if (clear) begin
            m_infl.delete();
            m_fifo.delete();
            m_pv = 1'b0;
            m_hc = '0;
        end else begin
            pop = (m_fifo.size() > 0) && out_ready;
            if (pop) void'(m_fifo.pop_front());
            if (m_pv) begin
                if (m_fifo.size() < DEPTH) m_fifo.push_back(m_pn);
                else if (m_drop != 16'hFFFF) m_drop++;
            end
            m_pv = 1'b0;
            if (m_infl.size() > 0 && m_infl[0].c == cyc_n - LAT) begin
                t = m_infl.pop_front();
                m_hc++;
                if (ht < target) begin
                    m_pv = 1'b1;
                    m_pn = t.n;
                end
            end
            if (issue_valid) m_infl.push_back('{issue_nonce, cyc_n});
        end
    endtask

    // Core emulation: the hash for an issue appears LAT cycles later.
    task automatic cyc();
        logic [63:0] ht;
        core_q.push_back(issue_valid ? want_top : {$urandom, $urandom});
        ht = core_q.pop_front();
        hash[511:448] = ht;
        for (int i = 0; i < 14; i++) hash[i*32 +: 32] = $urandom;
        model_edge(ht);
        @(posedge clk);
        #1;
        cyc_n++;
        chk("out_valid", {63'd0, out_valid}, {63'd0, m_fifo.size() > 0});
        if (m_fifo.size() > 0) chk("out_nonce", {32'd0, out_nonce}, {32'd0, m_fifo[0]});
    endtask

    task automatic issue(logic [31:0] n, logic [63:0] top);
        issue_valid = 1'b1;
        issue_nonce = n;
        want_top    = top;
        cyc();
        issue_valid = 1'b0;
    endtask

    task automatic idle(int n);
        for (int i = 0; i < n; i++) cyc();
    endtask

    task automatic chk_counts(string tag);
        chk({tag, "_hcnt"}, {16'd0, hash_count}, {16'd0, m_hc});
        chk({tag, "_drop"}, {48'd0, drop_count}, {48'd0, m_drop});
    endtask

    task automatic measure_lat(string tag);
        int n;
        n = 0;
        while (!out_valid && n < 20) begin
            cyc();
            n++;
        end
        chk(tag, 64'(n), 64'(LAT + 1));
    endtask

    initial begin
        for (int i = 0; i < LAT; i++) core_q.push_back(64'hFFFF_FFFF_FFFF_FFFF);
        rst_n       = 1'b0;
        clear       = 1'b0;
        issue_valid = 1'b0;
        issue_nonce = '0;
        hash        = '0;
        target      = 64'h0000_0100_0000_0000;
        out_ready   = 1'b0;
        want_top    = '0;
        model_reset();
        #1;
        chk("rst_ovld", {63'd0, out_valid}, 64'd0);
        chk("rst_onon", {32'd0, out_nonce}, 64'd0);
        chk("rst_hcnt", {16'd0, hash_count}, 64'd0);
        chk("rst_drop", {48'd0, drop_count}, 64'd0);
        repeat (2) @(posedge clk);
        #3;
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // Single hit at the documented latency.
        issue(32'd453, 64'h0000_00FF_FFFF_FFFF);
        measure_lat("hit_lat");
        chk("hit_nonce", {32'd0, out_nonce}, 64'd453);
        chk("hit_hcnt", {16'd0, hash_count}, 64'd1);
        out_ready = 1'b1;
        cyc();
        out_ready = 1'b0;

        // Equal-to-target and zero target never hit.
        issue(32'd7, 64'h0000_0100_0000_0000);
        idle(LAT + 3);
        chk("eq_nohit", {63'd0, out_valid}, 64'd0);
        target = 64'd0;
        issue(32'd8, 64'd0);
        idle(LAT + 3);
        chk("zero_nohit", {63'd0, out_valid}, 64'd0);
        chk_counts("bnd");
        target = 64'h0000_0100_0000_0000;

        // Overflow: six hits into a four-deep FIFO.
        for (int i = 10; i < 16; i++) issue(32'(i), 64'd0);
        idle(LAT + 3);
        chk("ovf_drop", {48'd0, drop_count}, 64'd2);
        chk("ovf_head", {32'd0, out_nonce}, 64'd10);
        out_ready = 1'b1;
        idle(4);
        out_ready = 1'b0;
        chk("ovf_empty", {63'd0, out_valid}, 64'd0);

        // Full FIFO with a hit and a pop on the same edge.
        for (int i = 20; i < 24; i++) issue(32'(i), 64'd0);
        idle(LAT + 3);
        issue(32'd24, 64'd0);
        idle(LAT);
        out_ready = 1'b1;
        cyc();
        out_ready = 1'b0;
        chk("fp_drop", {48'd0, drop_count}, 64'd2);
        chk("fp_head", {32'd0, out_nonce}, 64'd21);
        out_ready = 1'b1;
        idle(4);
        out_ready = 1'b0;
        chk("fp_empty", {63'd0, out_valid}, 64'd0);

        // Clear with two queued and three in flight.
        issue(32'd30, 64'd0);
        issue(32'd31, 64'd0);
        idle(LAT + 3);
        issue(32'd32, 64'd0);
        issue(32'd33, 64'd0);
        issue(32'd34, 64'd0);
        clear = 1'b1;
        cyc();
        clear = 1'b0;
        chk("clr_ovld", {63'd0, out_valid}, 64'd0);
        idle(LAT + 3);
        chk("clr_hcnt", {16'd0, hash_count}, 64'd0);
        chk("clr_drop", {48'd0, drop_count}, 64'd2);
        chk_counts("clr");

        // Randomized traffic against the model.
        target = 64'h8000_0000_0000_0000;
        for (int i = 0; i < 400; i++) begin
            issue_valid = ($urandom_range(9) < 7);
            issue_nonce = $urandom;
            want_top    = ($urandom_range(15) == 0) ? target : {$urandom, $urandom};
            out_ready   = ($urandom_range(1) == 1);
            clear       = ($urandom_range(49) == 0);
            cyc();
        end
        issue_valid = 1'b0;
        clear       = 1'b0;
        out_ready   = 1'b0;
        idle(LAT + 3);
        chk_counts("rnd");

        // Asynchronous reset in the middle of traffic.
        for (int i = 0; i < 6; i++) issue(32'(100 + i), 64'd0);
        #3;
        rst_n = 1'b0;
        #1;
        chk("arst_ovld", {63'd0, out_valid}, 64'd0);
        chk("arst_onon", {32'd0, out_nonce}, 64'd0);
        chk("arst_hcnt", {16'd0, hash_count}, 64'd0);
        chk("arst_drop", {48'd0, drop_count}, 64'd0);
        model_reset();
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        target = 64'h0000_0100_0000_0000;
        issue(32'h77, 64'd5);
        measure_lat("rst_lat");
        chk("rst_nonce", {32'd0, out_nonce}, 64'h77);
        chk_counts("post_rst");

        $display("Result: errors=%0d of %0d checks", nerr, nchk);
        $finish;
    end

endmodule
